// File: rtl/accum_cpu_ctrl_if.sv
// RAM-side bus of the accumulator CPU: address, write data/strobe, combinational read data.
interface accum_cpu_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_write;

    modport master (output ram_addr, output ram_din, output ram_write, input ram_dout);
    modport slave  (input ram_addr, input ram_din, input ram_write, output ram_dout);
endinterface

// File: rtl/accum_cpu_ctrl.sv
// Multi-cycle (FETCH/DECODE/EXECUTE) accumulator CPU controller for a 256x16 single-port RAM.
// Optional IN/OUT opcodes and io_* ports are enabled by defining ACCUM_CPU_IO_EN.
module accum_cpu_ctrl #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    accum_cpu_ctrl_if.master  bus,
`ifdef ACCUM_CPU_IO_EN
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_valid,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              halted
);

    localparam logic [1:0] StFetch  = 2'd0;
    localparam logic [1:0] StDecode = 2'd1;
    localparam logic [1:0] StExec   = 2'd2;
    localparam logic [1:0] StHalt   = 2'd3;

    localparam logic [3:0] OpLoad  = 4'h1;
    localparam logic [3:0] OpStore = 4'h2;
    localparam logic [3:0] OpAdd   = 4'h3;
    localparam logic [3:0] OpSub   = 4'h4;
    localparam logic [3:0] OpJmp   = 4'h5;
    localparam logic [3:0] OpJz    = 4'h6;
    localparam logic [3:0] OpJc    = 4'h7;
    localparam logic [3:0] OpAnd   = 4'h8;
    localparam logic [3:0] OpLdi   = 4'h9;
`ifdef ACCUM_CPU_IO_EN
    localparam logic [3:0] OpIn    = 4'hC;
    localparam logic [3:0] OpOut   = 4'hD;
`endif
    localparam logic [3:0] OpHalt  = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              unused_ir_bits;

    assign opcode         = ir_q[DATA_W-1 -: 4];
    assign operand        = ir_q[ADDR_W-1:0];
    assign unused_ir_bits = ^ir_q[DATA_W-5:ADDR_W];
    // Bit DATA_W of the extended result is carry for ADD and borrow for SUB.
    assign sum            = {1'b0, acc_q} + {1'b0, bus.ram_dout};
    assign diff           = {1'b0, acc_q} - {1'b0, bus.ram_dout};

    assign bus.ram_addr  = (state_q == StDecode || state_q == StExec) ? operand : pc_q;
    assign bus.ram_din   = acc_q;
    assign bus.ram_write = (state_q == StExec) && (opcode == OpStore);

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign carry  = carry_q;
    assign halted = (state_q == StHalt);

`ifdef ACCUM_CPU_IO_EN
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              io_valid_q, io_valid_d;

    assign io_out       = io_out_q;
    assign io_out_valid = io_valid_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
`ifdef ACCUM_CPU_IO_EN
        io_out_d   = io_out_q;
        io_valid_d = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                if (run) begin
                    ir_d    = bus.ram_dout;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                state_d = StFetch;
                case (opcode)
                    OpLoad: acc_d = bus.ram_dout;
                    OpAdd:  {carry_d, acc_d} = sum;
                    OpSub:  {carry_d, acc_d} = diff;
                    OpJmp:  pc_d = operand;
                    OpJz:   if (acc_q == '0) pc_d = operand;
                    OpJc:   if (carry_q) pc_d = operand;
                    OpAnd:  acc_d = acc_q & bus.ram_dout;
                    OpLdi:  acc_d = DATA_W'(operand);
`ifdef ACCUM_CPU_IO_EN
                    OpIn:   acc_d = io_in;
                    OpOut: begin
                        io_out_d   = acc_q;
                        io_valid_d = 1'b1;
                    end
`endif
                    OpHalt: state_d = StHalt;
                    default: ;
                endcase
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

`ifdef ACCUM_CPU_IO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_out_q   <= '0;
            io_valid_q <= 1'b0;
        end else begin
            io_out_q   <= io_out_d;
            io_valid_q <= io_valid_d;
        end
    end
`endif

endmodule
